fetch_unit: RTL and testbench

- Parametrised successor to the fixed PC register / +4 adder / PC mux front end.
- Owns the program counter, drives the combinational instruction memory, and buffers fetched {pc, instruction} pairs in a small FIFO.
- Hands entries to decode over a valid/ready handshake, so decode stalls no longer stop the PC blindly.
- Accepts a redirect (branch/jump target) from execute that flushes the buffer.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
// The FETCH_MISALIGN_CHECK_EN build uses fetch_state_t for its trap FSM.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and a head read straight
// from storage registers. DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is reset too (cheap at this depth) so the head reads 0 after reset;
      // all state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational imem port, fetch buffer and decode handshake.
// Define FETCH_MISALIGN_CHECK_EN to add misalign_o and the RUN/TRAP misaligned-redirect FSM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int                    ADDR_WIDTH = 32,
  parameter  int                    DATA_WIDTH = 32,
  parameter  logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter  int                    FIFO_DEPTH = 2,
  localparam int                    CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_instr_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic [CW-1:0]         fifo_count_o
);

  logic [ADDR_WIDTH-1:0]            r_pc;
  logic                             w_pop;
  logic                             w_push;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_run;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
  fetch_state_t r_state;
  fetch_state_t w_state_next;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves the next state unassigned (no latch).
    w_state_next = r_state;
    if (redirect_i) w_state_next = (redirect_pc_i[1:0] != 2'b00) ? TRAP : RUN;
  end

  assign w_run      = (r_state == RUN);
  assign misalign_o = (r_state == TRAP);
`else
  assign w_run = 1'b1;
`endif

  assign w_pop  = id_valid_o && id_ready_i;
  assign w_push = w_run && !redirect_i && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset)           r_pc <= RESET_PC;
    else if (redirect_i) r_pc <= redirect_pc_i;
    else if (w_push)     r_pc <= r_pc + ADDR_WIDTH'(PC_STEP);
  end

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_wdata ({r_pc, imem_rdata_i}),
    .o_head  (w_head),
    .o_count (fifo_count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr_o             = r_pc;
  assign id_valid_o              = !w_empty;
  assign {id_pc_o, id_instr_o}   = w_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised self-checking bench for fetch_unit against a queue-based fetch model.
// Honours FETCH_MISALIGN_CHECK_EN when the design is built with it.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [1:0]  fifo_count_o;
  logic        misalign_o;

  logic        w2_reset;
  logic [31:0] w2_addr;
  logic [31:0] w2_rdata;
  logic        w2_valid;
  logic [31:0] w2_pc;
  logic [31:0] w2_instr;
  logic [1:0]  w2_count;
  logic        w2_mis;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a[4:2] == 3'd7) return INSTR_NOP;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata_i = imem(imem_addr_o);
  assign w2_rdata     = imem(w2_addr);

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_o    (misalign_o),
`endif
    .fifo_count_o  (fifo_count_o)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk           (clk),
    .reset         (w2_reset),
    .imem_addr_o   (w2_addr),
    .imem_rdata_i  (w2_rdata),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .id_valid_o    (w2_valid),
    .id_ready_i    (1'b1),
    .id_pc_o       (w2_pc),
    .id_instr_o    (w2_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_o    (w2_mis),
`endif
    .fifo_count_o  (w2_count)
  );

`ifndef FETCH_MISALIGN_CHECK_EN
  assign misalign_o = 1'b0;
  assign w2_mis     = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the buffer as a queue of {pc, instr}, plus the next fetch address.
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic         m_trap    = 1'b0;
  logic         m_cleared = 1'b0;
  logic         m_known   = 1'b0;

  task automatic check_outputs();
    if (!m_known) return;
    check("addr",  {32'h0, imem_addr_o},  {32'h0, m_pc});
    check("valid", {63'h0, id_valid_o},   {63'h0, m_q.size() != 0});
    check("count", {62'h0, fifo_count_o}, 64'(m_q.size()));
    check("mis",   {63'h0, misalign_o},   {63'h0, m_trap});
    if (m_q.size() != 0) begin
      check("head_pc",    {32'h0, id_pc_o},    {32'h0, m_q[0].pc});
      check("head_instr", {32'h0, id_instr_o}, {32'h0, m_q[0].instr});
    end else if (m_cleared) begin
      check("rst_head", {id_pc_o, id_instr_o}, 64'h0);
    end
  endtask

  task automatic model_step(input logic rst, input logic rd, input logic [31:0] rpc,
                            input logic rdy);
    fetch_entry_t e;
    logic pop, push;
    if (rst) begin
      m_q.delete();
      m_pc      = RST_PC;
      m_trap    = 1'b0;
      m_cleared = 1'b1;
      m_known   = 1'b1;
      return;
    end
    if (!m_known) return;
    pop = (m_q.size() != 0) && rdy;
    if (rd) begin
      m_q.delete();
      m_pc = rpc;
`ifdef FETCH_MISALIGN_CHECK_EN
      m_trap = (rpc[1:0] != 2'b00);
`endif
      return;
    end
    push = !m_trap && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.pc    = m_pc;
      e.instr = imem(m_pc);
      m_q.push_back(e);
      m_pc      = m_pc + 32'(PC_STEP);
      m_cleared = 1'b0;
    end
  endtask

  // Called just after a falling edge: drive, settle, compare, advance model and clock.
  task automatic cycle(input logic rst, input logic rd, input logic [31:0] rpc, input logic rdy);
    reset         = rst;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    id_ready_i    = rdy;
    #1;
    check_outputs();
    model_step(rst, rd, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
    w2_reset = 1'b1;
    @(negedge clk);

    // Sequential fetch with decode always ready.
    cycle(1, 0, 0, 1); cycle(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

    // Decode stalled: buffer fills and PC holds, then drains without a gap.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

    // Redirect with a full buffer and a simultaneous pop.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h100, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

    // Alternating ready.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, i[0]);

`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(0, 1, 32'h102, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h200, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
`endif

    // Random traffic, including redirects and mid-run resets.
    for (int i = 0; i < 400; i++) begin
      rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
`endif
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, rpc,
            $urandom_range(0, 3) != 0);
    end

    // PC wrap from a reset PC near the top of the address space.
    w2_reset = 1'b1;
    @(negedge clk);
    w2_reset = 1'b0;
    #1;
    check("wrap_addr0",  {32'h0, w2_addr}, {32'h0, WRAP_PC});
    check("wrap_valid0", {63'h0, w2_valid}, 64'h0);
    check("wrap_head0",  {w2_pc, w2_instr}, 64'h0);
    check("wrap_mis",    {63'h0, w2_mis}, 64'h0);
    @(negedge clk); #1;
    check("wrap_addr1",  {32'h0, w2_addr}, 64'hFFFF_FFFC);
    check("wrap_pc1",    {32'h0, w2_pc},   {32'h0, WRAP_PC});
    check("wrap_ins1",   {32'h0, w2_instr}, {32'h0, imem(WRAP_PC)});
    @(negedge clk); #1;
    check("wrap_addr2",  {32'h0, w2_addr}, 64'h0);
    check("wrap_pc2",    {32'h0, w2_pc},   64'hFFFF_FFFC);
    check("wrap_count2", {62'h0, w2_count}, 64'h1);
    @(negedge clk); #1;
    check("wrap_addr3",  {32'h0, w2_addr}, 64'h4);
    check("wrap_pc3",    {32'h0, w2_pc},   64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
